// File: rtl/exec_pipe.sv
// Pipelined execute stage: NUM_ALU single-cycle ALU lanes plus one MUL_LAT-deep multiplier lane,
// each with valid/ready handshakes on issue and result; results carry {result, tag1, tag0}.
module exec_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned IMM_W   = 5,
    parameter int unsigned NUM_ALU = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic [NUM_ALU-1:0]                    alu_in_valid,
    output logic [NUM_ALU-1:0]                    alu_in_ready,
    input  logic [NUM_ALU*(DATA_W+TAG_W)-1:0]     alu_r0,
    input  logic [NUM_ALU*(DATA_W+TAG_W)-1:0]     alu_r1,
    input  logic [NUM_ALU*IMM_W-1:0]              alu_imm,
    input  logic [NUM_ALU-1:0]                    alu_imm_sel,
    input  logic [NUM_ALU*4-1:0]                  alu_op,
    output logic [NUM_ALU-1:0]                    alu_res_valid,
    input  logic [NUM_ALU-1:0]                    alu_res_ready,
    output logic [NUM_ALU*(DATA_W+2*TAG_W)-1:0]   alu_res,

    input  logic                                  mul_in_valid,
    output logic                                  mul_in_ready,
    input  logic [DATA_W+TAG_W-1:0]               mul_r0,
    input  logic [DATA_W+TAG_W-1:0]               mul_r1,
    input  logic [IMM_W-1:0]                      mul_imm,
    input  logic                                  mul_imm_sel,
    output logic                                  mul_res_valid,
    input  logic                                  mul_res_ready,
    output logic [DATA_W+2*TAG_W-1:0]             mul_res,
    output logic                                  mul_busy
);

    localparam int unsigned OPND_W = DATA_W + TAG_W;
    localparam int unsigned RES_W  = DATA_W + 2 * TAG_W;
    localparam int unsigned SH_W   = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    // ALU lanes: one output register each, refilled in the same cycle it drains
    for (genvar i = 0; i < NUM_ALU; i++) begin : g_alu
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag0;
        logic [TAG_W-1:0]  tag1;
        logic [SH_W-1:0]   sh;
        logic              res_v;
        logic [RES_W-1:0]  res_q;
        logic              accept;

        always_comb begin
            a      = alu_r0[i*OPND_W+TAG_W +: DATA_W];
            tag0   = alu_r0[i*OPND_W +: TAG_W];
            b      = alu_imm_sel[i] ? DATA_W'(alu_imm[i*IMM_W +: IMM_W])
                                    : alu_r1[i*OPND_W+TAG_W +: DATA_W];
            tag1   = alu_imm_sel[i] ? '0 : alu_r1[i*OPND_W +: TAG_W];
            sh     = b[SH_W-1:0];
            result = '0;
            case (alu_op[i*4 +: 4])
                OP_ADD:  result = a + b;
                OP_SUB:  result = a - b;
                OP_AND:  result = a & b;
                OP_OR:   result = a | b;
                OP_XOR:  result = a ^ b;
                OP_SLL:  result = a << sh;
                OP_SRL:  result = a >> sh;
                OP_SRA:  result = DATA_W'($signed(a) >>> sh);
                default: result = '0;
            endcase
        end

        assign alu_in_ready[i] = !res_v || alu_res_ready[i];
        assign accept          = alu_in_valid[i] && alu_in_ready[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                res_v <= 1'b0;
                res_q <= '0;
            end else if (accept) begin
                res_v <= 1'b1;
                res_q <= {result, tag1, tag0};
            end else if (alu_res_ready[i]) begin
                res_v <= 1'b0;
            end
        end

        assign alu_res_valid[i]         = res_v;
        assign alu_res[i*RES_W +: RES_W] = res_q;
    end

    // Multiplier lane: stage 0 in the low slice, output stage in the high slice
    logic [DATA_W-1:0]        ma;
    logic [DATA_W-1:0]        mb;
    logic [DATA_W-1:0]        mprod;
    logic [TAG_W-1:0]         mtag0;
    logic [TAG_W-1:0]         mtag1;
    logic [RES_W-1:0]         stage0;
    logic                     advance;
    logic [MUL_LAT-1:0]       mv;
    logic [MUL_LAT-1:0]       mv_shift;
    logic [MUL_LAT-1:0]       mv_nxt;
    logic [MUL_LAT*RES_W-1:0] md;
    logic [MUL_LAT*RES_W-1:0] md_shift;
    logic [MUL_LAT*RES_W-1:0] md_nxt;
    logic                     busy_q;

    always_comb begin
        ma     = mul_r0[OPND_W-1:TAG_W];
        mtag0  = mul_r0[TAG_W-1:0];
        mb     = mul_imm_sel ? DATA_W'(mul_imm) : mul_r1[OPND_W-1:TAG_W];
        mtag1  = mul_imm_sel ? '0 : mul_r1[TAG_W-1:0];
        mprod  = ma * mb;
        stage0 = {mprod, mtag1, mtag0};
    end

    if (MUL_LAT > 1) begin : g_shift
        assign mv_shift = {mv[MUL_LAT-2:0], mul_in_valid};
        assign md_shift = {md[(MUL_LAT-1)*RES_W-1:0], stage0};
    end else begin : g_single
        assign mv_shift = mul_in_valid;
        assign md_shift = stage0;
    end

    // A full output stage that is not being drained freezes every stage
    assign advance      = !(mv[MUL_LAT-1] && !mul_res_ready);
    assign mul_in_ready = advance;

    always_comb begin
        mv_nxt = mv;
        md_nxt = md;
        if (advance) begin
            mv_nxt = mv_shift;
            md_nxt = md_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv     <= '0;
            md     <= '0;
            busy_q <= 1'b0;
        end else begin
            mv     <= mv_nxt;
            md     <= md_nxt;
            busy_q <= |mv_nxt;
        end
    end

    assign mul_res_valid = mv[MUL_LAT-1];
    assign mul_res       = md[MUL_LAT*RES_W-1 -: RES_W];
    assign mul_busy      = busy_q;

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe: table of single-op ALU vectors plus hand-written
// throughput, backpressure, multiplier latency/stall and mid-operation reset sequences.
module tb_exec_pipe;

    localparam int DW = 16;
    localparam int TW = 5;
    localparam int IW = 5;
    localparam int NA = 2;
    localparam int ML = 3;
    localparam int OW = DW + TW;
    localparam int RW = DW + 2 * TW;

    logic                clk = 1'b0;
    logic                rst;
    logic [NA-1:0]       alu_in_valid;
    logic [NA-1:0]       alu_in_ready;
    logic [NA*OW-1:0]    alu_r0;
    logic [NA*OW-1:0]    alu_r1;
    logic [NA*IW-1:0]    alu_imm;
    logic [NA-1:0]       alu_imm_sel;
    logic [NA*4-1:0]     alu_op;
    logic [NA-1:0]       alu_res_valid;
    logic [NA-1:0]       alu_res_ready;
    logic [NA*RW-1:0]    alu_res;
    logic                mul_in_valid;
    logic                mul_in_ready;
    logic [OW-1:0]       mul_r0;
    logic [OW-1:0]       mul_r1;
    logic [IW-1:0]       mul_imm;
    logic                mul_imm_sel;
    logic                mul_res_valid;
    logic                mul_res_ready;
    logic [RW-1:0]       mul_res;
    logic                mul_busy;

    exec_pipe #(
        .DATA_W (DW),
        .TAG_W  (TW),
        .IMM_W  (IW),
        .NUM_ALU(NA),
        .MUL_LAT(ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_in_valid (alu_in_valid),
        .alu_in_ready (alu_in_ready),
        .alu_r0       (alu_r0),
        .alu_r1       (alu_r1),
        .alu_imm      (alu_imm),
        .alu_imm_sel  (alu_imm_sel),
        .alu_op       (alu_op),
        .alu_res_valid(alu_res_valid),
        .alu_res_ready(alu_res_ready),
        .alu_res      (alu_res),
        .mul_in_valid (mul_in_valid),
        .mul_in_ready (mul_in_ready),
        .mul_r0       (mul_r0),
        .mul_r1       (mul_r1),
        .mul_imm      (mul_imm),
        .mul_imm_sel  (mul_imm_sel),
        .mul_res_valid(mul_res_valid),
        .mul_res_ready(mul_res_ready),
        .mul_res      (mul_res),
        .mul_busy     (mul_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lane;
        logic [3:0]  op;
        logic [15:0] a;
        logic [4:0]  at;
        logic [15:0] b;
        logic [4:0]  bt;
        logic [4:0]  imm;
        logic        sel;
        logic [15:0] exp;
    } vec_t;

    vec_t          vecs[$];
    logic [RW-1:0] mexp[$];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic lane, input logic [3:0] op, input logic [15:0] a,
                                input logic [4:0] at, input logic [15:0] b, input logic [4:0] bt,
                                input logic [4:0] imm, input logic sel, input logic [15:0] exp);
        vec_t v;
        v.lane = lane; v.op = op; v.a = a; v.at = at; v.b = b; v.bt = bt;
        v.imm = imm; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    function automatic logic [RW-1:0] pack(input logic [15:0] d, input logic [4:0] t1,
                                           input logic [4:0] t0);
        return {d, t1, t0};
    endfunction

    task automatic alu_set(input logic lane, input logic [3:0] op, input logic [15:0] a,
                           input logic [4:0] at, input logic [15:0] b, input logic [4:0] bt,
                           input logic [4:0] imm, input logic sel, input logic v);
        alu_r0[lane*OW +: OW]  = {a, at};
        alu_r1[lane*OW +: OW]  = {b, bt};
        alu_imm[lane*IW +: IW] = imm;
        alu_imm_sel[lane]      = sel;
        alu_op[lane*4 +: 4]    = op;
        alu_in_valid[lane]     = v;
    endtask

    task automatic mul_set(input logic [15:0] a, input logic [4:0] at, input logic [15:0] b,
                           input logic [4:0] bt, input logic [4:0] imm, input logic sel,
                           input logic v);
        mul_r0       = {a, at};
        mul_r1       = {b, bt};
        mul_imm      = imm;
        mul_imm_sel  = sel;
        mul_in_valid = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int stray;

        rst = 1'b1;
        alu_in_valid = '0; alu_r0 = '0; alu_r1 = '0; alu_imm = '0; alu_imm_sel = '0;
        alu_op = '0; alu_res_ready = '0;
        mul_in_valid = 1'b0; mul_r0 = '0; mul_r1 = '0; mul_imm = '0; mul_imm_sel = 1'b0;
        mul_res_ready = 1'b0;
        step();
        step();
        chk("rst_alu_valid", 64'(alu_res_valid), 64'(0));
        chk("rst_alu_res", 64'(alu_res), 64'(0));
        chk("rst_mul_valid", 64'(mul_res_valid), 64'(0));
        chk("rst_mul_busy", 64'(mul_busy), 64'(0));
        chk("rst_mul_res", 64'(mul_res), 64'(0));
        rst = 1'b0;
        alu_res_ready = 2'b11;
        mul_res_ready = 1'b1;
        #1;
        chk("rst_alu_ready", 64'(alu_in_ready), 64'(2'b11));
        chk("rst_mul_ready", 64'(mul_in_ready), 64'(1));

        // single ALU operations: lane, op, a, atag, b, btag, imm, imm_sel, expected
        vecs.push_back(mk(1'b0, 4'd0,  16'h0010, 5'd3,  16'h0000, 5'd0,  5'd5,  1'b1, 16'h0015));
        vecs.push_back(mk(1'b1, 4'd1,  16'h0000, 5'd3,  16'h0001, 5'd7,  5'd0,  1'b0, 16'hFFFF));
        vecs.push_back(mk(1'b1, 4'd7,  16'h8000, 5'd1,  16'h1234, 5'd9,  5'd4,  1'b1, 16'hF800));
        vecs.push_back(mk(1'b0, 4'd2,  16'hF0F0, 5'd2,  16'h3C3C, 5'd4,  5'd0,  1'b0, 16'h3030));
        vecs.push_back(mk(1'b1, 4'd3,  16'hF000, 5'd0,  16'h000F, 5'd31, 5'd0,  1'b0, 16'hF00F));
        vecs.push_back(mk(1'b0, 4'd4,  16'hFFFF, 5'd5,  16'h0F0F, 5'd6,  5'd0,  1'b0, 16'hF0F0));
        vecs.push_back(mk(1'b0, 4'd5,  16'h0001, 5'd1,  16'h0013, 5'd9,  5'd0,  1'b0, 16'h0008));
        vecs.push_back(mk(1'b1, 4'd6,  16'h8000, 5'd2,  16'h0000, 5'd0,  5'd15, 1'b1, 16'h0001));
        vecs.push_back(mk(1'b0, 4'd0,  16'hFFFF, 5'd1,  16'h0002, 5'd2,  5'd0,  1'b0, 16'h0001));
        vecs.push_back(mk(1'b1, 4'd9,  16'h1234, 5'd3,  16'h5678, 5'd4,  5'd0,  1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'd7,  16'h7000, 5'd8,  16'h0000, 5'd0,  5'd4,  1'b1, 16'h0700));
        vecs.push_back(mk(1'b0, 4'd15, 16'hABCD, 5'd10, 16'h1111, 5'd11, 5'd0,  1'b0, 16'h0000));

        foreach (vecs[k]) begin
            alu_set(vecs[k].lane, vecs[k].op, vecs[k].a, vecs[k].at, vecs[k].b, vecs[k].bt,
                    vecs[k].imm, vecs[k].sel, 1'b1);
            chk($sformatf("vec%0d_in_ready", k), 64'(alu_in_ready[vecs[k].lane]), 64'(1));
            step();
            alu_in_valid = '0;
            chk($sformatf("vec%0d_valid", k), 64'(alu_res_valid[vecs[k].lane]), 64'(1));
            chk($sformatf("vec%0d_other_idle", k), 64'(alu_res_valid[!vecs[k].lane]), 64'(0));
            chk($sformatf("vec%0d_res", k), 64'(alu_res[vecs[k].lane*RW +: RW]),
                64'(pack(vecs[k].exp, vecs[k].sel ? 5'd0 : vecs[k].bt, vecs[k].at)));
        end
        step();
        chk("vec_drain", 64'(alu_res_valid), 64'(0));

        // lane1 back-to-back: consume and accept in the same cycle, no bubble
        alu_set(1'b1, 4'd0, 16'd1, 5'd1, 16'd2, 5'd2, 5'd0, 1'b0, 1'b1);
        step();
        chk("tp_first", 64'(alu_res[RW +: RW]), 64'(pack(16'd3, 5'd2, 5'd1)));
        alu_set(1'b1, 4'd0, 16'd10, 5'd3, 16'd20, 5'd4, 5'd0, 1'b0, 1'b1);
        chk("tp_ready", 64'(alu_in_ready[1]), 64'(1));
        step();
        alu_in_valid = '0;
        chk("tp_second_valid", 64'(alu_res_valid[1]), 64'(1));
        chk("tp_second", 64'(alu_res[RW +: RW]), 64'(pack(16'd30, 5'd4, 5'd3)));
        step();
        chk("tp_idle", 64'(alu_res_valid[1]), 64'(0));

        // lane0 backpressure: result held, second op waits
        alu_res_ready[0] = 1'b0;
        alu_set(1'b0, 4'd0, 16'd1, 5'd1, 16'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step();
        alu_set(1'b0, 4'd0, 16'd3, 5'd3, 16'd4, 5'd4, 5'd0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_ready%0d", c), 64'(alu_in_ready[0]), 64'(0));
            chk($sformatf("bp_valid%0d", c), 64'(alu_res_valid[0]), 64'(1));
            chk($sformatf("bp_hold%0d", c), 64'(alu_res[0 +: RW]), 64'(pack(16'd2, 5'd2, 5'd1)));
            step();
        end
        alu_res_ready[0] = 1'b1;
        #1;
        chk("bp_release_ready", 64'(alu_in_ready[0]), 64'(1));
        step();
        alu_in_valid = '0;
        chk("bp_second_valid", 64'(alu_res_valid[0]), 64'(1));
        chk("bp_second", 64'(alu_res[0 +: RW]), 64'(pack(16'd7, 5'd4, 5'd3)));
        step();
        chk("bp_idle", 64'(alu_res_valid[0]), 64'(0));

        // multiplier latency
        mul_set(16'h0012, 5'd1, 16'h0003, 5'd2, 5'd0, 1'b0, 1'b1);
        chk("mul_in_ready", 64'(mul_in_ready), 64'(1));
        step();
        mul_in_valid = 1'b0;
        chk("mul_busy_t1", 64'(mul_busy), 64'(1));
        chk("mul_valid_t1", 64'(mul_res_valid), 64'(0));
        step();
        chk("mul_valid_t2", 64'(mul_res_valid), 64'(0));
        step();
        chk("mul_valid_t3", 64'(mul_res_valid), 64'(1));
        chk("mul_res_t3", 64'(mul_res), 64'(pack(16'h0036, 5'd2, 5'd1)));
        step();
        chk("mul_valid_t4", 64'(mul_res_valid), 64'(0));
        chk("mul_busy_t4", 64'(mul_busy), 64'(0));

        // multiplier back-to-back
        mexp.delete();
        mul_set(16'h0100, 5'd1, 16'h0100, 5'd2, 5'd0, 1'b0, 1'b1);
        mexp.push_back(pack(16'h0000, 5'd2, 5'd1));
        step();
        mul_set(16'h0005, 5'd3, 16'hABCD, 5'd9, 5'd7, 1'b1, 1'b1);
        mexp.push_back(pack(16'h0023, 5'd0, 5'd3));
        step();
        mul_set(16'h1234, 5'd5, 16'h0002, 5'd6, 5'd0, 1'b0, 1'b1);
        mexp.push_back(pack(16'h2468, 5'd6, 5'd5));
        step();
        mul_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_valid%0d", k), 64'(mul_res_valid), 64'(1));
            chk($sformatf("b2b_res%0d", k), 64'(mul_res), 64'(mexp[k]));
            step();
        end
        chk("b2b_idle", 64'(mul_res_valid), 64'(0));

        // multiplier stall with three in flight
        mexp.delete();
        mul_res_ready = 1'b0;
        mul_set(16'h0007, 5'd1, 16'h0006, 5'd2, 5'd0, 1'b0, 1'b1);
        mexp.push_back(pack(16'h002A, 5'd2, 5'd1));
        step();
        mul_set(16'hFFFF, 5'd3, 16'hFFFF, 5'd4, 5'd0, 1'b0, 1'b1);
        mexp.push_back(pack(16'h0001, 5'd4, 5'd3));
        step();
        mul_set(16'h0100, 5'd5, 16'h0000, 5'd0, 5'd3, 1'b1, 1'b1);
        mexp.push_back(pack(16'h0300, 5'd0, 5'd5));
        step();
        mul_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall_ready%0d", c), 64'(mul_in_ready), 64'(0));
            chk($sformatf("stall_valid%0d", c), 64'(mul_res_valid), 64'(1));
            chk($sformatf("stall_hold%0d", c), 64'(mul_res), 64'(mexp[0]));
            step();
        end
        chk("stall_busy", 64'(mul_busy), 64'(1));
        mul_res_ready = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (mul_res_valid) begin
                if (got < 3)
                    chk($sformatf("drain_res%0d", got), 64'(mul_res), 64'(mexp[got]));
                got++;
            end
            step();
        end
        chk("drain_count", 64'(got), 64'(3));

        // reset with every lane holding work
        alu_res_ready = 2'b00;
        mul_res_ready = 1'b0;
        alu_set(1'b0, 4'd0, 16'h0011, 5'd1, 16'h0022, 5'd2, 5'd0, 1'b0, 1'b1);
        alu_set(1'b1, 4'd4, 16'h00FF, 5'd3, 16'h0F00, 5'd4, 5'd0, 1'b0, 1'b1);
        mul_set(16'h0003, 5'd1, 16'h0003, 5'd2, 5'd0, 1'b0, 1'b1);
        step();
        alu_in_valid = '0;
        mul_set(16'h0004, 5'd3, 16'h0004, 5'd4, 5'd0, 1'b0, 1'b1);
        step();
        chk("pre_rst_alu_valid", 64'(alu_res_valid), 64'(2'b11));
        chk("pre_rst_busy", 64'(mul_busy), 64'(1));
        rst = 1'b1;
        alu_in_valid = 2'b11;
        step();
        rst = 1'b0;
        alu_in_valid = '0;
        mul_in_valid = 1'b0;
        chk("post_rst_alu_valid", 64'(alu_res_valid), 64'(0));
        chk("post_rst_alu_res", 64'(alu_res), 64'(0));
        chk("post_rst_mul_valid", 64'(mul_res_valid), 64'(0));
        chk("post_rst_mul_res", 64'(mul_res), 64'(0));
        chk("post_rst_busy", 64'(mul_busy), 64'(0));
        chk("post_rst_alu_ready", 64'(alu_in_ready), 64'(2'b11));
        chk("post_rst_mul_ready", 64'(mul_in_ready), 64'(1));
        alu_res_ready = 2'b11;
        mul_res_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            if (mul_res_valid || (alu_res_valid != 2'b00))
                stray++;
            step();
        end
        chk("post_rst_no_stale", 64'(stray), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_pipe.md
Name: exec_pipe

Overview:
- Parametrised, pipelined successor to the combinational execute stage.
- Provides NUM_ALU independent ALU lanes and one MUL_LAT-stage multiplier lane.
- Each lane has a valid/ready handshake on both its issue side and its result side.
- Sits between the issue/reservation stage and the writeback/tag-broadcast bus. Results carry the source tags, packed {result, tag1, tag0}.

Parameters:
- DATA_W, 16, operand/result data width.
- TAG_W, 5, tag width per operand.
- IMM_W, 5, immediate width; zero-extended to DATA_W.
- NUM_ALU, 2, number of ALU lanes (>=1).
- MUL_LAT, 3, multiplier pipeline depth in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_in_valid  in  NUM_ALU  per-lane issue valid.
- alu_in_ready  out  NUM_ALU  per-lane issue ready.
- alu_r0  in  NUM_ALU*(DATA_W+TAG_W)  operand A per lane, {data, tag}.
- alu_r1  in  NUM_ALU*(DATA_W+TAG_W)  operand B per lane, {data, tag}.
- alu_imm  in  NUM_ALU*IMM_W  immediate per lane.
- alu_imm_sel  in  NUM_ALU  1 = use immediate as B.
- alu_op  in  NUM_ALU*4  opcode per lane.
- alu_res_valid  out  NUM_ALU  result valid.
- alu_res_ready  in  NUM_ALU  result accepted by consumer.
- alu_res  out  NUM_ALU*(DATA_W+2*TAG_W)  {result, tag1, tag0} per lane.
- mul_in_valid  in  1  multiplier issue valid.
- mul_in_ready  out  1  multiplier issue ready.
- mul_r0  in  DATA_W+TAG_W  operand A, {data, tag}.
- mul_r1  in  DATA_W+TAG_W  operand B, {data, tag}.
- mul_imm  in  IMM_W  immediate.
- mul_imm_sel  in  1  1 = use immediate as B.
- mul_res_valid  out  1  result valid.
- mul_res_ready  in  1  result accepted by consumer.
- mul_res  out  DATA_W+2*TAG_W  {product, tag1, tag0}.
- mul_busy  out  1  OR of all multiplier stage valids.

Behaviour:
- Lane i occupies bit slice [i*W +: W] of each packed vector. Operand data is [DATA_W+TAG_W-1:TAG_W]; tag is [TAG_W-1:0].
- B = imm_sel ? zero-extended imm : r1 data. tag1 = imm_sel ? 0 : r1 tag. tag0 = r0 tag.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[$clog2(DATA_W)-1:0].
  - 8–15 produce result 0 (tags still passed).
- All arithmetic wraps mod 2^DATA_W. MUL result is the low DATA_W bits of the unsigned product.
- Handshakes:
  - Transfer occurs on valid && ready.
  - While res_valid && !res_ready, res is held stable.
  - Input ready never depends combinationally on in_valid.
- ALU lane (one output register each, lanes fully independent):
  - alu_in_ready[i] = !alu_res_valid[i] || alu_res_ready[i].
  - On accept: result registered; res_valid=1 the next cycle (latency 1).
  - If res is consumed with no new accept: res_valid -> 0.
  - Simultaneous consume and accept: new result replaces old with no bubble; throughput 1/cycle.
- MUL lane (MUL_LAT stages, each with a valid bit; output = last stage):
  - advance = !(v_last && !mul_res_ready); mul_in_ready = advance.
  - When advance=1, all stages shift and stage 1 loads the accepted op (or a bubble if no accept).
  - When advance=0, the whole pipe freezes.
  - Latency is exactly MUL_LAT cycles from accept to res_valid when unstalled. Throughput 1/cycle; order preserved.
  - Bubbles do not stall the pipe.
- Reset (synchronous; also applies mid-operation):
  - All res_valid and stage valids -> 0.
  - res data and tags -> 0.
  - mul_busy -> 0.
  - in_ready outputs are 1 in the first cycle after reset.
  - In-flight operations are discarded; no result is produced for them after reset.
- Inputs presented during a rst cycle are ignored.

Test Plan (DATA_W=16, TAG_W=5, IMM_W=5, NUM_ALU=2, MUL_LAT=3):
1. Lane0 ADD, r0={0x0010,tag 3}, imm=5, imm_sel=1, res_ready=1 -> next cycle res_valid[0]=1, res={0x0015,0,3}; lane1 stays invalid.
2. Lane1 SUB, r0={0x0000,tag 3}, r1={0x0001,tag 7} -> res={0xFFFF,7,3}. Then SRA on 0x8000 by imm 4 -> 0xF800.
3. Lane0 with res_ready=0 for 3 cycles and a second op pending -> in_ready[0]=0 and res held unchanged; res_ready=1 -> first result consumed, second result valid the following cycle.
4. MUL: 0x0012*0x0003 accepted at cycle t -> mul_res={0x0036,tag1,tag0} valid at t+3. Three back-to-back issues -> three consecutive valid outputs; 0x0100*0x0100 -> 0x0000.
5. MUL with 3 ops in flight, mul_res_ready=0 for 4 cycles -> mul_in_ready=0, output held; on release all 3 results emerge in order with none lost or duplicated.
6. Pipe full (mul_busy=1, all alu_res_valid=1), rst=1 for one cycle -> next cycle all valids=0, mul_busy=0, all in_ready=1; no stale results afterwards.
